// File: rtl/exponent_mm_master.sv
// Avalon-MM initiator that drives the exponent accelerator: writes BASE/EXP/GO, polls STATUS, reads RESULT.
// Optional poll timeout with an error output: define EXP_MASTER_TIMEOUT_EN.
module exponent_mm_master #(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE   = '0,
    parameter int                POLL_LIMIT = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] exp,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
`ifdef EXP_MASTER_TIMEOUT_EN
    ,
    output logic              error
`endif
);

    localparam logic [ADDR_W-1:0] A_BASE = SLV_BASE;
    localparam logic [ADDR_W-1:0] A_EXP  = SLV_BASE + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CTRL = SLV_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STAT = SLV_BASE + ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_RES  = SLV_BASE + ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_BASE, S_WR_EXP, S_WR_GO, S_RD_STAT, S_RD_GAP, S_RD_RES, S_DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_exp;
`ifdef EXP_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_LIMIT + 1);
    logic [CNT_W-1:0]  r_poll_cnt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_exp         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
`ifdef EXP_MASTER_TIMEOUT_EN
            r_poll_cnt    <= '0;
            error         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // base lives in avm_writedata for the whole WR_BASE transfer
                        r_exp         <= exp;
                        busy          <= 1'b1;
                        avm_write     <= 1'b1;
                        avm_address   <= A_BASE;
                        avm_writedata <= base;
                        r_state       <= S_WR_BASE;
`ifdef EXP_MASTER_TIMEOUT_EN
                        error         <= 1'b0;
`endif
                    end
                end
                S_WR_BASE: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= A_EXP;
                        avm_writedata <= r_exp;
                        r_state       <= S_WR_EXP;
                    end
                end
                S_WR_EXP: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= A_CTRL;
                        avm_writedata <= DATA_W'(1);
                        r_state       <= S_WR_GO;
                    end
                end
                S_WR_GO: begin
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= A_STAT;
                        r_state     <= S_RD_STAT;
`ifdef EXP_MASTER_TIMEOUT_EN
                        r_poll_cnt  <= '0;
`endif
                    end
                end
                S_RD_STAT: begin
                    if (!avm_waitrequest) begin
                        if (avm_readdata[0]) begin
                            avm_address <= A_RES;
                            r_state     <= S_RD_RES;
                        end else begin
                            avm_read <= 1'b0;
`ifdef EXP_MASTER_TIMEOUT_EN
                            if (r_poll_cnt == CNT_W'(POLL_LIMIT - 1)) begin
                                result  <= '1;
                                error   <= 1'b1;
                                done    <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_poll_cnt <= r_poll_cnt + CNT_W'(1);
                                r_state    <= S_RD_GAP;
                            end
`else
                            r_state  <= S_RD_GAP;
`endif
                        end
                    end
                end
                S_RD_GAP: begin
                    avm_read <= 1'b1;
                    r_state  <= S_RD_STAT;
                end
                S_RD_RES: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        result   <= avm_readdata;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
